// File: rtl/rx_serial_fifo.sv
// Receive buffer behind the serial receiver: captures {erro, dado} on each pronto
// pulse into a circular FIFO and presents the oldest entry first-word-fall-through.
module rx_serial_fifo #(
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            limpa,
  input  logic            pronto,
  input  logic [7:0]      dado,
  input  logic            erro,
  input  logic            le,
  output logic [7:0]      dado_saida,
  output logic            erro_saida,
  output logic            vazio,
  output logic            cheio,
  output logic [ADDR:0]   ocupacao,
  output logic            overflow,
  output logic [1:0]      db_estado
);

  localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

  logic [8:0]      r_mem [DEPTH];
  logic [ADDR-1:0] r_wr;
  logic [ADDR-1:0] r_rd;
  logic [ADDR:0]   r_cnt;
  logic            r_ovf;

  logic       w_pop;
  logic       w_wr;
  logic       w_drop;
  logic [8:0] w_head;

  assign vazio  = (r_cnt == '0);
  assign cheio  = (r_cnt == FULL_CNT);
  assign w_pop  = le & ~vazio;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_wr   = pronto & (~cheio | w_pop);
  assign w_drop = pronto & cheio & ~w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (limpa) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage is never cleared; pointers and count alone decide visibility.
  always_ff @(posedge clock) begin
    if (w_wr && !limpa) r_mem[r_wr] <= {erro, dado};
  end

  assign w_head     = r_mem[r_rd];
  assign dado_saida = vazio ? 8'h00 : w_head[7:0];
  assign erro_saida = vazio ? 1'b0  : w_head[8];
  assign ocupacao   = r_cnt;
  assign overflow   = r_ovf;

  always_comb begin
    db_estado = 2'b01;
    if (r_ovf)      db_estado = 2'b11;
    else if (cheio) db_estado = 2'b10;
    else if (vazio) db_estado = 2'b00;
  end

endmodule

// File: doc/rx_serial_fifo.md
# rx_serial_fifo

Receive buffer placed directly downstream of the serial receiver's control unit and data path. It captures each received byte, with its parity-error flag, on the receiver's one-cycle `pronto` pulse and stores it in a small circular FIFO. It presents the oldest entry to the consumer in first-word-fall-through form, so a slow consumer does not lose bytes arriving back-to-back.

## Interface

Parameters:
- `DEPTH`, default 8: number of entries; a power of two, minimum 2.
- `ADDR`, default 3: pointer width, equal to log2(`DEPTH`).

Ports:
- `clock`  in  1: single system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `limpa`  in  1: synchronous clear; empties the FIFO and clears `overflow`.
- `pronto`  in  1: one-cycle pulse from the receiver; `dado` and `erro` are valid in this cycle.
- `dado`  in  8: received byte.
- `erro`  in  1: parity error flag for `dado`.
- `le`  in  1: read/pop strobe from the consumer, sampled each cycle.
- `dado_saida`  out  8: head entry data; 0 when empty.
- `erro_saida`  out  1: head entry error flag; 0 when empty.
- `vazio`  out  1: FIFO empty.
- `cheio`  out  1: FIFO full.
- `ocupacao`  out  ADDR+1: number of stored entries, from 0 to `DEPTH`.
- `overflow`  out  1: sticky flag; a byte was dropped because the FIFO was full.
- `db_estado`  out  2: debug code; 00 = empty, 01 = partial, 10 = full, 11 = overflow latched (this code takes priority).

## Operation

Storage and pointers:
- Storage is `DEPTH` x 9 bits: {`erro`, `dado`}.
- Write pointer and read pointer are each `ADDR` bits.
- The occupancy counter is `ADDR+1` bits.
- Pointers wrap modulo `DEPTH` with no special case.

Write and read conditions:
- Write occurs when `pronto`=1 and either the FIFO is not full, or it is full and a pop happens in the same cycle.
- On a write, the entry is stored at the write pointer and the write pointer increments.
- Pop occurs when `le`=1 and `vazio`=0. On a pop, the read pointer increments.
- `le` while empty is ignored. It changes no state and raises no flag.

Occupancy update:
- Write only: `ocupacao` +1.
- Pop only: `ocupacao` -1.
- Both in one cycle: unchanged.
- Neither: unchanged.

Flag and output derivation:
- `vazio` = (`ocupacao`==0); `cheio` = (`ocupacao`==`DEPTH`). Both are derived from the registered counter.
- Overflow: `pronto`=1 while full with no simultaneous pop drops the byte and sets `overflow`=1. `overflow` holds until `limpa` or `reset`.
- `dado_saida`/`erro_saida` are taken combinationally from the storage entry at the read pointer, gated to 0 when `vazio`=1.

Clear behaviour:
- `limpa`=1 has priority over write and pop in the same cycle.
- It zeroes both pointers, `ocupacao` and `overflow`.
- Stored contents are not cleared; they are simply no longer visible.

## Timing

- Reset values: `vazio`=1, `cheio`=0, `ocupacao`=0, `overflow`=0, `dado_saida`=0, `erro_saida`=0, `db_estado`=00. Pointers are 0.
- Reset takes effect immediately, including mid-operation; all stored bytes are discarded.
- Write latency: a byte written on edge N appears on `dado_saida` and `vazio` falls after edge N, if the FIFO was empty before.
- Pop: the consumer samples `dado_saida` in the same cycle it asserts `le`. The next entry, or 0 and `vazio`=1, appears after that edge.
- Holding `le` high continuously pops one entry per cycle until empty.
- Write and pop simultaneously while empty: the pop is ignored, the write is accepted, and `ocupacao` becomes 1.
- Write and pop simultaneously while full: both are performed, `ocupacao` stays `DEPTH`, and `overflow` is not set.
- `pronto` is at most one cycle wide per byte. A multi-cycle `pronto` writes once per high cycle; callers must not rely on that.

## Test plan

- Reset then idle: all outputs equal their reset values; `le` pulses while empty leave `ocupacao`=0 and `overflow`=0.
- Write 0x41 (`erro`=0) then 0x5A (`erro`=1): `ocupacao`=2. The first pop sees `dado_saida`=0x41, `erro_saida`=0. The next cycle shows 0x5A, `erro_saida`=1. After the second pop, `vazio`=1 and `dado_saida`=0.
- Fill with 0x00..0x07 (`DEPTH`=8): `cheio`=1 and `db_estado`=10. A further write of 0xFF sets `overflow`=1 and `db_estado`=11. Draining returns 0x00..0x07 in order; 0xFF never appears.
- Full FIFO with `pronto`(0xAA) and `le` in the same cycle: 0x00 is popped, `ocupacao` stays 8, and `overflow` stays 0. After 7 more pops the head is 0xAA.
- Wrap-around: 20 write/pop pairs with values 0x10..0x23, each pair separated by idle cycles. Every byte is read back in order and `ocupacao` never exceeds 1.
- `limpa` with 5 entries stored and `overflow`=1, asserted together with `pronto`: afterwards `vazio`=1, `ocupacao`=0 and `overflow`=0, and the concurrent byte is dropped. Also assert `reset` asynchronously mid-fill and check an immediate return to reset values.
